// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory access arbiter.
// DATA_WIDTH may be predefined by the build; it falls back to 32 bits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package dm_arb_pkg;

  typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} dm_owner_e;

  localparam int         DM_ADDR_W   = 14;
  localparam int         DM_DATA_W   = `DATA_WIDTH;
  localparam logic [3:0] DM_WEB_NONE = 4'hF;

  typedef struct packed {
    logic                 we;
    logic [3:0]           web;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
  } dm_req_t;

  localparam dm_req_t DM_REQ_IDLE = '{we: 1'b0, web: DM_WEB_NONE,
                                      addr: {DM_ADDR_W{1'b0}}, wdata: {DM_DATA_W{1'b0}}};

  // Reads and idle cycles must never write a byte lane.
  function automatic logic [3:0] req_web(input dm_req_t req);
    return req.we ? req.web : DM_WEB_NONE;
  endfunction

endpackage

// File: rtl/dm_starve_counter.sv
// Saturating wait counter with synchronous clear; tracks how long the
// external port has been kept waiting.
module dm_starve_counter #(
  parameter int LIMIT = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count up while requested, hold at LIMIT, clear on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_W'(LIMIT))) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/dm_access_arbiter.sv
// Arbitrates the single-port DM SRAM between the CPU MEM stage and an external port.
// Build option DM_ARB_RR_EN: round-robin instead of CPU priority with starvation override.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_web,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [3:0]        ext_web,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              dm_cs,
  output logic [3:0]        dm_web,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_di,
  input  logic [DATA_W-1:0] dm_do
);

  localparam int CNT_W = 8;

  logic             cpu_grant_s;
  logic             ext_grant_s;
  logic             starve_inc_s;
  logic             starve_clr_s;
  logic [CNT_W-1:0] starve_cnt_s;
  logic             rd_pend_r;
  dm_owner_e        rd_owner_r;
  dm_req_t          cpu_pkt_s;
  dm_req_t          ext_pkt_s;
  dm_req_t          sel_pkt_s;

  assign cpu_pkt_s = '{we: cpu_we, web: cpu_web, addr: DM_ADDR_W'(cpu_addr), wdata: DM_DATA_W'(cpu_wdata)};
  assign ext_pkt_s = '{we: ext_we, web: ext_web, addr: DM_ADDR_W'(ext_addr), wdata: DM_DATA_W'(ext_wdata)};

`ifdef DM_ARB_RR_EN
  dm_owner_e last_owner_r;

  // Remember who used the SRAM last so contention alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_r <= OWN_CPU;
    end else if (cpu_grant_s) begin
      last_owner_r <= OWN_CPU;
    end else if (ext_grant_s) begin
      last_owner_r <= OWN_EXT;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  assign starve_inc_s = 1'b0;
  assign starve_clr_s = 1'b1;
`else
  assign starve_inc_s = ext_req & ~ext_grant_s;
  assign starve_clr_s = ~starve_inc_s;
`endif

  dm_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc_s),
    .clr (starve_clr_s),
    .cnt (starve_cnt_s)
  );

  // Single-grant decision; nothing is granted while in reset.
  always_comb begin
    cpu_grant_s = 1'b0;
    ext_grant_s = 1'b0;
    if (rst) begin
      cpu_grant_s = 1'b0;
    end else if (cpu_req && ext_req) begin
`ifdef DM_ARB_RR_EN
      if (last_owner_r == OWN_CPU) begin
        ext_grant_s = 1'b1;
      end else begin
        cpu_grant_s = 1'b1;
      end
`else
      if (starve_cnt_s == CNT_W'(STARVE_LIMIT)) begin
        ext_grant_s = 1'b1;
      end else begin
        cpu_grant_s = 1'b1;
      end
`endif
    end else if (cpu_req) begin
      cpu_grant_s = 1'b1;
    end else if (ext_req) begin
      ext_grant_s = 1'b1;
    end else begin
      cpu_grant_s = 1'b0;
    end
  end

  // Steer the granted port onto the SRAM pins.
  always_comb begin
    sel_pkt_s = DM_REQ_IDLE;
    case ({cpu_grant_s, ext_grant_s})
      2'b10:   sel_pkt_s = cpu_pkt_s;
      2'b01:   sel_pkt_s = ext_pkt_s;
      default: sel_pkt_s = DM_REQ_IDLE;
    endcase
  end

  assign dm_cs     = cpu_grant_s | ext_grant_s;
  assign dm_web    = req_web(sel_pkt_s);
  assign dm_addr   = ADDR_W'(sel_pkt_s.addr);
  assign dm_di     = DATA_W'(sel_pkt_s.wdata);
  assign cpu_stall = cpu_req & ~cpu_grant_s & ~rst;
  assign ext_gnt   = ext_grant_s;

  // Note which port issued last cycle's read so dm_do is routed back to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= OWN_CPU;
    end else if (cpu_grant_s && !cpu_we) begin
      rd_pend_r  <= 1'b1;
      rd_owner_r <= OWN_CPU;
    end else if (ext_grant_s && !ext_we) begin
      rd_pend_r  <= 1'b1;
      rd_owner_r <= OWN_EXT;
    end else begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= rd_owner_r;
    end
  end

  assign cpu_rvalid = rd_pend_r & (rd_owner_r == OWN_CPU);
  assign ext_rvalid = rd_pend_r & (rd_owner_r == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? dm_do : {DATA_W{1'b0}};
  assign ext_rdata  = ext_rvalid ? dm_do : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed self-checking bench for dm_access_arbiter (default STARVE_LIMIT=8).
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [3:0]  cpu_web, ext_web, dm_web;
  logic [13:0] cpu_addr, ext_addr, dm_addr;
  logic [31:0] cpu_wdata, ext_wdata, dm_di, dm_do;
  logic        cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, dm_cs;
  logic [31:0] cpu_rdata, ext_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_access_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_web(cpu_web), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_web(ext_web), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .dm_cs(dm_cs), .dm_web(dm_web), .dm_addr(dm_addr), .dm_di(dm_di), .dm_do(dm_do)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sram_idle(input string tag);
    check_value({tag, " dm_cs"}, 64'(dm_cs), 64'd0);
    check_value({tag, " dm_web"}, 64'(dm_web), 64'hF);
    check_value({tag, " dm_addr"}, 64'(dm_addr), 64'd0);
    check_value({tag, " dm_di"}, 64'(dm_di), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_web = 4'h0; cpu_addr = 14'h5; cpu_wdata = 32'h1234;
    ext_req = 1'b1; ext_we = 1'b1; ext_web = 4'h0; ext_addr = 14'h6; ext_wdata = 32'h5678;
    dm_do = 32'h0;
    tick(); tick();

    // Reset: requests pending but nothing granted
    check_sram_idle("rst");
    check_value("rst cpu_stall", 64'(cpu_stall), 64'd0);
    check_value("rst ext_gnt", 64'(ext_gnt), 64'd0);
    check_value("rst cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check_value("rst ext_rvalid", 64'(ext_rvalid), 64'd0);
    rst = 1'b0; cpu_req = 1'b0; ext_req = 1'b0;
    tick();
    check_sram_idle("idle");

    // CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_web = 4'h0; cpu_addr = 14'h10;
    #1;
    check_value("rd cs", 64'(dm_cs), 64'd1);
    check_value("rd web", 64'(dm_web), 64'hF);
    check_value("rd addr", 64'(dm_addr), 64'h10);
    check_value("rd stall", 64'(cpu_stall), 64'd0);
    tick();
    cpu_req = 1'b0; dm_do = 32'hDEADBEEF;
    #1;
    check_value("rd cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check_value("rd cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    check_value("rd ext_rvalid", 64'(ext_rvalid), 64'd0);
    check_value("rd ext_rdata", 64'(ext_rdata), 64'd0);

    // CPU byte write
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_web = 4'b1101; cpu_addr = 14'h22; cpu_wdata = 32'h0000AB00;
    #1;
    check_value("wr web", 64'(dm_web), 64'hD);
    check_value("wr di", 64'(dm_di), 64'h0000AB00);
    check_value("wr addr", 64'(dm_addr), 64'h22);
    tick();
    cpu_req = 1'b0;
    #1;
    check_value("wr no rvalid", 64'(cpu_rvalid), 64'd0);
    check_value("wr rdata zero", 64'(cpu_rdata), 64'd0);

    // External write with no lanes enabled: selected but writes nothing
    ext_req = 1'b1; ext_we = 1'b1; ext_web = 4'hF; ext_addr = 14'h3F; ext_wdata = 32'hCAFEF00D;
    #1;
    check_value("extwF gnt", 64'(ext_gnt), 64'd1);
    check_value("extwF cs", 64'(dm_cs), 64'd1);
    check_value("extwF web", 64'(dm_web), 64'hF);
    check_value("extwF di", 64'(dm_di), 64'hCAFEF00D);
    tick();
    ext_req = 1'b0;
    #1;
    check_value("extwF no rvalid", 64'(ext_rvalid), 64'd0);

    // Alternating reads: CPU then ext, data returned to each owner
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h30;
    #1;
    check_value("alt cpu cs", 64'(dm_cs), 64'd1);
    tick();
    cpu_req = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 14'h31; dm_do = 32'h11111111;
    #1;
    check_value("alt ext gnt", 64'(ext_gnt), 64'd1);
    check_value("alt ext addr", 64'(dm_addr), 64'h31);
    check_value("alt cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check_value("alt cpu_rdata", 64'(cpu_rdata), 64'h11111111);
    check_value("alt ext_rvalid early", 64'(ext_rvalid), 64'd0);
    tick();
    ext_req = 1'b0; dm_do = 32'h22222222;
    #1;
    check_value("alt ext_rvalid", 64'(ext_rvalid), 64'd1);
    check_value("alt ext_rdata", 64'(ext_rdata), 64'h22222222);
    check_value("alt cpu_rvalid late", 64'(cpu_rvalid), 64'd0);
    check_value("alt cpu_rdata zero", 64'(cpu_rdata), 64'd0);
    tick();
    check_value("alt quiet", 64'(ext_rvalid | cpu_rvalid), 64'd0);

`ifndef DM_ARB_RR_EN
    // Contention: CPU holds 8 cycles, ext force-granted on the 9th
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 14'h2;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      dm_do = 32'(cyc);
      #1;
      check_value($sformatf("cont%0d stall", cyc), 64'(cpu_stall), (cyc == 9) ? 64'd1 : 64'd0);
      check_value($sformatf("cont%0d ext_gnt", cyc), 64'(ext_gnt), (cyc == 9) ? 64'd1 : 64'd0);
      check_value($sformatf("cont%0d addr", cyc), 64'(dm_addr), (cyc == 9) ? 64'h2 : 64'h1);
      if (cyc == 10) begin
        check_value("cont10 ext_rvalid", 64'(ext_rvalid), 64'd1);
        check_value("cont10 ext_rdata", 64'(ext_rdata), 64'd10);
      end else if (cyc >= 2) begin
        check_value($sformatf("cont%0d cpu_rvalid", cyc), 64'(cpu_rvalid), 64'd1);
      end else begin
        check_value("cont1 cpu_rvalid", 64'(cpu_rvalid), 64'd0);
      end
      tick();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();
`endif

    // Reset mid-read: the granted read still returns, then everything quiet
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h40;
    tick();
    rst = 1'b1; dm_do = 32'h5A5A5A5A;
    #1;
    check_value("rstrd cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check_value("rstrd cpu_rdata", 64'(cpu_rdata), 64'h5A5A5A5A);
    check_value("rstrd stall", 64'(cpu_stall), 64'd0);
    check_sram_idle("rstrd");
    tick();
    check_value("rstrd after rvalid", 64'(cpu_rvalid), 64'd0);
    check_value("rstrd after rdata", 64'(cpu_rdata), 64'd0);
    rst = 1'b0; cpu_req = 1'b0;
    tick();

`ifdef DM_ARB_RR_EN
    // Round-robin: last_owner is CPU after reset, so ext goes first
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 14'h2;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      check_value($sformatf("rr%0d ext_gnt", cyc), 64'(ext_gnt), (cyc % 2 == 0) ? 64'd1 : 64'd0);
      check_value($sformatf("rr%0d stall", cyc), 64'(cpu_stall), (cyc % 2 == 0) ? 64'd1 : 64'd0);
      tick();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
